// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the fetch next-PC unit
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] INSTR_BYTES_DEF = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } pq_entry_t;

endpackage

// File: rtl/fetch_pc_unit_pred_queue.sv
// rtl/fetch_pc_unit_pred_queue.sv - in-order FIFO of taken predictions awaiting resolution
module pred_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  pq_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       clear,
    output pq_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves the same cycle.
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !clear && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch next-PC generator with prediction check; FETCH_PERF_CNT_EN adds branch/mispredict counters
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              PQ_DEPTH    = 4,
    parameter logic [PC_W-1:0] INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [PC_W-1:0]  f_pc,
    output logic             f_valid,
    input  logic [PC_W-1:0]  bp_predict_addr,
    input  logic             bp_predict_valid,
    input  logic             x_resolve,
    input  logic [PC_W-1:0]  x_pc,
    input  logic             x_taken,
    input  logic [PC_W-1:0]  x_target,
    output logic             flush,
    output logic             pq_full
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]      perf_branches,
    output logic [15:0]      perf_mispredicts
`endif
);

    localparam int CW = $clog2(PQ_DEPTH) + 1;

    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic            f_valid_q, f_valid_d;
    logic            flush_q, flush_d;

    pq_entry_t       pq_head;
    pq_entry_t       pq_push_data;
    logic [CW-1:0]   pq_count;
    logic            pq_full_w;
    logic            pq_empty;
    logic            pq_push;
    logic            pq_pop;
    logic            head_hit;
    logic            mispredict;

    pred_queue #(.DEPTH(PQ_DEPTH)) u_pred_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pq_push),
        .push_data (pq_push_data),
        .pop       (pq_pop),
        .clear     (mispredict),
        .head      (pq_head),
        .count     (pq_count),
        .full      (pq_full_w),
        .empty     (pq_empty)
    );

    always_comb begin
        head_hit   = !pq_empty && (pq_head.pc == x_pc);
        mispredict = x_resolve && (head_hit ? (!x_taken || (pq_head.target != x_target))
                                            : x_taken);
        pq_pop     = x_resolve && head_hit;

        pq_push             = 1'b0;
        pq_push_data.pc     = f_pc_q;
        pq_push_data.target = bp_predict_addr;
        f_pc_d              = f_pc_q;
        f_valid_d           = f_valid_q;
        flush_d             = mispredict;

        if (mispredict) begin
            f_pc_d    = x_taken ? x_target : (x_pc + INSTR_BYTES);
            f_valid_d = 1'b1;
        end else if (stall) begin
            f_pc_d    = f_pc_q;
        end else if (!f_valid_q) begin
            // First cycle out of reset fetches RESET_PC itself.
            f_valid_d = 1'b1;
        end else if (bp_predict_valid && (!pq_full_w || pq_pop)) begin
            f_pc_d  = bp_predict_addr;
            pq_push = 1'b1;
        end else begin
            f_pc_d = f_pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc_q    <= RESET_PC;
            f_valid_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            flush_q   <= flush_d;
        end
    end

    assign f_pc    = f_pc_q;
    assign f_valid = f_valid_q;
    assign flush   = flush_q;
    assign pq_full = (pq_count == CW'(PQ_DEPTH));

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_branches_q, perf_branches_d;
    logic [15:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (x_resolve && (perf_branches_q != 16'hFFFF))
            perf_branches_d = perf_branches_q + 16'd1;
        if (mispredict && (perf_mispredicts_q != 16'hFFFF))
            perf_mispredicts_d = perf_mispredicts_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= 16'd0;
            perf_mispredicts_q <= 16'd0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
